rdout_sequencer: RTL and testbench

//  Frame-level controller for the 10-bit count readout path (single-word port, increment/clr/done handshake).

---
 rtl/rdout_pkg.sv | 28 ++
 rtl/rr_arb2.sv | 31 +++
 rtl/rdout_sequencer.sv | 148 ++++++++++++++
 tb/tb_rdout_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rdout_pkg.sv
// Shared constants and types for the readout frame sequencer.
package rdout_pkg;

    localparam int unsigned N_WORDS_DEF  = 52;
    localparam int unsigned RD_LAT_DEF   = 3;
    localparam int unsigned DONE_TMO_DEF = 15;
    localparam logic [9:0]  HDR_WORD_DEF = 10'h234;
    localparam logic [9:0]  TRL_WORD_DEF = 10'h2BF;

    // Bank index: 0 = A, 1 = B
    typedef logic bank_t;

    // Sequencer FSM state encoding
    localparam logic [3:0] StIdle  = 4'd0;
    localparam logic [3:0] StHdr   = 4'd1;
    localparam logic [3:0] StInc   = 4'd2;
    localparam logic [3:0] StLat   = 4'd3;
    localparam logic [3:0] StSend  = 4'd4;
    localparam logic [3:0] StWdone = 4'd5;
    localparam logic [3:0] StTrl   = 4'd6;
    localparam logic [3:0] StClr   = 4'd7;
    localparam logic [3:0] StAck   = 4'd8;

    function automatic logic [1:0] bank_onehot(bank_t b);
        return b ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the bank preferred on a tie.
module rr_arb2
    import rdout_pkg::*;
(
    input  logic       clk50,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    input  bank_t      served_idx,
    output bank_t      grant_idx,
    output logic       grant_vld
);

    bank_t ptr_q;

    // Preferred bank wins if requesting, otherwise the other one
    always_comb begin
        grant_vld = |req;
        grant_idx = req[ptr_q] ? ptr_q : ~ptr_q;
    end

    // After a frame completes, prefer the bank that was not just served
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else if (advance) begin
            ptr_q <= ~served_idx;
        end
    end

endmodule

// File: rtl/rdout_sequencer.sv
// Frame-level readout sequencer: arbitrates banks, paces increments, frames words to serializer.
module rdout_sequencer
    import rdout_pkg::*;
#(
    parameter int unsigned N_WORDS  = N_WORDS_DEF,
    parameter int unsigned RD_LAT   = RD_LAT_DEF,
    parameter int unsigned DONE_TMO = DONE_TMO_DEF,
    parameter logic [9:0]  HDR_WORD = HDR_WORD_DEF,
    parameter logic [9:0]  TRL_WORD = TRL_WORD_DEF
) (
    input  logic       clk50,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [1:0] frame_req,
    output logic [1:0] frame_ack,
    output logic       bank_sel,
    output logic       increment,
    output logic       clr_rdout,
    input  logic [9:0] rd_word,
    input  logic       rd_done,
    output logic [9:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       err_trl
);

    localparam int unsigned TMR_MAX = (DONE_TMO > RD_LAT) ? DONE_TMO : RD_LAT;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX) + 1;

    logic [3:0]       state_q, state_d;
    bank_t            bank_q, bank_d;
    logic [6:0]       cnt_q, cnt_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [9:0]       txd_q, txd_d;
    logic             err_q, err_d;
    logic             advance;
    bank_t            grant_idx;
    logic             grant_vld;

    rr_arb2 u_arb (
        .clk50      (clk50),
        .rst_n      (rst_n),
        .req        (frame_req),
        .advance    (advance),
        .served_idx (bank_q),
        .grant_idx  (grant_idx),
        .grant_vld  (grant_vld)
    );

    // Next-state: frame sequencing, word counting, latency/timeout timer, tx holding register
    always_comb begin
        state_d = state_q;
        bank_d  = bank_q;
        cnt_d   = cnt_q;
        tmr_d   = tmr_q;
        txd_d   = txd_q;
        err_d   = err_q;
        advance = 1'b0;
        case (state_q)
            StIdle: begin
                if (enable && grant_vld) begin
                    state_d = StHdr;
                    bank_d  = grant_idx;
                    cnt_d   = 7'd0;
                    err_d   = 1'b0;
                    txd_d   = HDR_WORD;
                end
            end
            StHdr: if (tx_ready) state_d = StInc;
            StInc: begin
                state_d = StLat;
                tmr_d   = TMR_W'(RD_LAT - 1);
            end
            StLat: begin
                if (tmr_q == '0) begin
                    state_d = StSend;
                    txd_d   = rd_word;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            StSend: begin
                if (tx_ready) begin
                    cnt_d = cnt_q + 7'd1;
                    if (cnt_q + 7'd1 == 7'(N_WORDS)) begin
                        state_d = StWdone;
                        tmr_d   = TMR_W'(DONE_TMO - 1);
                    end else begin
                        state_d = StInc;
                    end
                end
            end
            StWdone: begin
                if (rd_done) begin
                    state_d = StTrl;
                    txd_d   = rd_word;
                    if (rd_word != TRL_WORD) err_d = 1'b1;
                end else if (tmr_q == '0) begin
                    // No trailer is sent on timeout
                    state_d = StClr;
                    err_d   = 1'b1;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            StTrl: if (tx_ready) state_d = StClr;
            StClr: state_d = StAck;
            StAck: begin
                state_d = StIdle;
                advance = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            bank_q  <= 1'b0;
            cnt_q   <= 7'd0;
            tmr_q   <= '0;
            txd_q   <= 10'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            txd_q   <= txd_d;
            err_q   <= err_d;
        end
    end

    // Outputs decoded from state and holding registers
    always_comb begin
        tx_valid  = (state_q == StHdr) || (state_q == StSend) || (state_q == StTrl);
        tx_data   = txd_q;
        increment = (state_q == StInc);
        clr_rdout = (state_q == StClr);
        frame_ack = (state_q == StAck) ? bank_onehot(bank_q) : 2'b00;
        busy      = (state_q != StIdle);
        bank_sel  = bank_q;
        err_trl   = err_q;
    end

endmodule

// File: tb/tb_rdout_sequencer.sv
// Scoreboard bench for rdout_sequencer with a behavioural readout port model.
module tb_rdout_sequencer;

    localparam int NW = 52;

    logic       clk50 = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [1:0] frame_req;
    logic [1:0] frame_ack;
    logic       bank_sel;
    logic       increment;
    logic       clr_rdout;
    logic [9:0] rd_word;
    logic       rd_done;
    logic [9:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       err_trl;

    rdout_sequencer dut (
        .clk50     (clk50),
        .rst_n     (rst_n),
        .enable    (enable),
        .frame_req (frame_req),
        .frame_ack (frame_ack),
        .bank_sel  (bank_sel),
        .increment (increment),
        .clr_rdout (clr_rdout),
        .rd_word   (rd_word),
        .rd_done   (rd_done),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .err_trl   (err_trl)
    );

    always #10 clk50 = ~clk50;

    typedef struct {
        logic [1:0] ack;
        logic       err;
        int         incs;
        int         clrs;
    } ack_t;

    logic [9:0] exp_q[$];
    ack_t       ack_q[$];
    int         errors = 0;
    int         checks = 0;
    int         ack_seen = 0;
    int         frame_words = 0;
    int         inc_cnt = 0;
    int         clr_cnt = 0;
    logic       prev_stall = 1'b0;
    logic       prev_inc = 1'b0;
    logic [9:0] prev_data = 10'd0;
    logic       rnd_mode = 1'b0;
    logic       withhold = 1'b0;
    logic [9:0] trl_val = 10'h2BF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] mk_word(input logic b, input int i);
        logic [7:0] lo;
        lo = 8'(i * 3 + 1);
        return {1'b0, b, lo};
    endfunction

    // Readout port model: word appears RD_LAT clocks after the increment rise
    logic [2:0] pipe;
    int         widx;
    int         dcnt;
    always @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            pipe    <= 3'b0;
            widx    <= 0;
            dcnt    <= 0;
            rd_word <= 10'd0;
            rd_done <= 1'b0;
        end else begin
            pipe <= {pipe[1:0], increment};
            if (clr_rdout) begin
                widx    <= 0;
                dcnt    <= 0;
                rd_done <= 1'b0;
            end else if (pipe[1]) begin
                rd_word <= mk_word(bank_sel, widx);
                widx    <= widx + 1;
                if (widx == NW - 1) dcnt <= 4;
            end else if (dcnt != 0) begin
                dcnt <= dcnt - 1;
                if (dcnt == 1 && !withhold) begin
                    rd_done <= 1'b1;
                    rd_word <= trl_val;
                end
            end
        end
    end

    // Serializer ready: always high, or high ~70% of cycles
    always @(posedge clk50) begin
        #1;
        tx_ready = rnd_mode ? ($urandom_range(0, 99) >= 30) : 1'b1;
    end

    // Monitor: pops expected words and frame completions as the DUT presents them
    always @(negedge clk50) begin
        if (!rst_n) begin
            prev_stall  = 1'b0;
            prev_inc    = 1'b0;
            inc_cnt     = 0;
            clr_cnt     = 0;
            frame_words = 0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 32'(tx_valid), 32'd1);
                chk("hold_data", 32'(tx_data), 32'(prev_data));
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected: got %0h expected none", tx_data);
                end else begin
                    chk("tx_word", 32'(tx_data), 32'(exp_q.pop_front()));
                end
                frame_words++;
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            if (increment) begin
                chk("inc_gap", 32'(prev_inc), 32'd0);
                chk("inc_pending", 32'(tx_valid), 32'd0);
                inc_cnt++;
            end
            prev_inc = increment;
            if (clr_rdout) clr_cnt++;
            if (frame_ack != 2'b00) begin
                ack_seen++;
                if (ack_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ack_unexpected: got %0b expected none", frame_ack);
                end else begin
                    ack_t e;
                    e = ack_q.pop_front();
                    chk("frame_ack", 32'(frame_ack), 32'(e.ack));
                    chk("ack_bank", 32'(bank_sel), 32'(e.ack[1]));
                    chk("ack_err", 32'(err_trl), 32'(e.err));
                    chk("ack_incs", 32'(inc_cnt), 32'(e.incs));
                    chk("ack_clrs", 32'(clr_cnt), 32'(e.clrs));
                end
                inc_cnt     = 0;
                clr_cnt     = 0;
                frame_words = 0;
            end
        end
    end

    task automatic push_frame(input logic b, input logic [9:0] trl, input logic wh);
        ack_t e;
        exp_q.push_back(10'h234);
        for (int i = 0; i < NW; i++) exp_q.push_back(mk_word(b, i));
        if (!wh) exp_q.push_back(trl);
        e.ack  = b ? 2'b10 : 2'b01;
        e.err  = wh || (trl != 10'h2BF);
        e.incs = NW;
        e.clrs = 1;
        ack_q.push_back(e);
    endtask

    task automatic wait_busy();
        int n = 0;
        while (!busy && n < 200) begin
            @(negedge clk50);
            n++;
        end
        chk("grant_timeout", 32'(n < 200), 32'd1);
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (!(exp_q.size() == 0 && ack_q.size() == 0 && !busy) && n < bound) begin
            @(negedge clk50);
            n++;
        end
        chk("frame_timeout", 32'(n < bound), 32'd1);
    endtask

    initial begin
        int base;
        int n;
        rst_n     = 1'b0;
        enable    = 1'b1;
        frame_req = 2'b00;
        tx_ready  = 1'b1;
        repeat (3) @(negedge clk50);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(tx_valid), 32'd0);
        chk("rst_ack", 32'(frame_ack), 32'd0);
        chk("rst_inc", 32'(increment), 32'd0);
        chk("rst_clr", 32'(clr_rdout), 32'd0);
        chk("rst_err", 32'(err_trl), 32'd0);
        chk("rst_bank", 32'(bank_sel), 32'd0);
        chk("rst_data", 32'(tx_data), 32'd0);
        rst_n = 1'b1;
        @(negedge clk50);

        // Single A frame, ready tied high
        push_frame(1'b0, 10'h2BF, 1'b0);
        frame_req = 2'b01;
        wait_busy();
        frame_req = 2'b00;
        wait_idle(3000);

        // Both banks held: A was last served, so B, A, B
        base = ack_seen;
        push_frame(1'b1, 10'h2BF, 1'b0);
        push_frame(1'b0, 10'h2BF, 1'b0);
        push_frame(1'b1, 10'h2BF, 1'b0);
        frame_req = 2'b11;
        n = 0;
        while (ack_seen < base + 2 && n < 3000) begin
            @(negedge clk50);
            n++;
        end
        chk("rr_timeout", 32'(n < 3000), 32'd1);
        @(negedge clk50);
        wait_busy();
        frame_req = 2'b00;
        wait_idle(3000);

        // Random backpressure on a B frame
        rnd_mode = 1'b1;
        push_frame(1'b1, 10'h2BF, 1'b0);
        frame_req = 2'b10;
        wait_busy();
        frame_req = 2'b00;
        wait_idle(5000);
        rnd_mode = 1'b0;

        // rd_done withheld: timeout, no trailer
        withhold = 1'b1;
        push_frame(1'b0, 10'h2BF, 1'b1);
        frame_req = 2'b01;
        wait_busy();
        frame_req = 2'b00;
        wait_idle(3000);
        chk("err_sticky", 32'(err_trl), 32'd1);
        withhold = 1'b0;

        // Bad trailer still sent; grant clears previous error
        trl_val = 10'h2AA;
        push_frame(1'b0, 10'h2AA, 1'b0);
        frame_req = 2'b01;
        wait_busy();
        chk("err_clear", 32'(err_trl), 32'd0);
        frame_req = 2'b00;
        wait_idle(3000);
        chk("err_badtrl", 32'(err_trl), 32'd1);
        trl_val = 10'h2BF;

        // enable low blocks grants
        push_frame(1'b0, 10'h2BF, 1'b0);
        enable    = 1'b0;
        frame_req = 2'b01;
        repeat (10) @(negedge clk50);
        chk("enable_block", 32'(busy), 32'd0);
        enable = 1'b1;
        wait_busy();
        frame_req = 2'b00;
        wait_idle(3000);

        // Reset mid-frame after 20 data words
        push_frame(1'b0, 10'h2BF, 1'b0);
        frame_req = 2'b01;
        n = 0;
        while (frame_words < 21 && n < 3000) begin
            @(negedge clk50);
            n++;
        end
        chk("word20_timeout", 32'(n < 3000), 32'd1);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        ack_q.delete();
        #1;
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_valid", 32'(tx_valid), 32'd0);
        chk("mrst_inc", 32'(increment), 32'd0);
        chk("mrst_data", 32'(tx_data), 32'd0);
        repeat (2) @(negedge clk50);
        push_frame(1'b0, 10'h2BF, 1'b0);
        rst_n = 1'b1;
        wait_busy();
        frame_req = 2'b00;
        wait_idle(3000);

        repeat (5) @(negedge clk50);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
